// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad entry controller:
// key codes, controller states and the default entry timeout.
package aclk_pkg;

    localparam logic [3:0] KEY_ALARM  = 4'hA;
    localparam logic [3:0] KEY_TIME   = 4'hB;
    localparam logic [3:0] KEY_NONE   = 4'hF;

    localparam logic [2:0] MAX_DIGITS = 3'd4;

    localparam int unsigned DEFAULT_TIMEOUT_SEC = 10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENTRY      = 2'd1,
        ST_SHOW_ALARM = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/aclk_key_edge.sv
// Keypad press detector: flags a digit/ALARM/TIME press when a key
// appears after a NOKEY sample. Outputs are combinational for the current edge.
module aclk_key_edge
    import aclk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    output logic       digit_evt,
    output logic       alarm_evt,
    output logic       time_evt
);

    logic [3:0] prev_q, prev_d;
    logic       armed_q, armed_d;
    logic       press;

    // prev resets to NOKEY, so armed blocks a key held across reset
    // release until a real NOKEY sample has been taken.
    always_comb begin
        prev_d  = key;
        armed_d = armed_q | (key == KEY_NONE);
        press   = armed_q && (prev_q == KEY_NONE) && (key != KEY_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= KEY_NONE;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign digit_evt = press && is_digit(key);
    assign alarm_evt = press && (key == KEY_ALARM);
    assign time_evt  = press && (key == KEY_TIME);

endmodule

// File: rtl/aclk_entry_ctrl.sv
// Alarm-clock time-entry controller: collects up to four keypad digits and
// commits them as alarm or current time, abandoning entry after a timeout.
module aclk_entry_ctrl
    import aclk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = DEFAULT_TIMEOUT_SEC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_new_time,
    output logic       show_a,
    output logic [2:0] digit_cnt
);

    localparam int unsigned TW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_SEC - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    digit_cnt_q, digit_cnt_d;
    logic          shift_q, shift_d;
    logic          load_a_q, load_a_d;
    logic          load_c_q, load_c_d;
    logic          show_new_time_q, show_new_time_d;
    logic          show_a_q, show_a_d;

    logic digit_evt, alarm_evt, time_evt;

    aclk_key_edge u_key_edge (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .digit_evt (digit_evt),
        .alarm_evt (alarm_evt),
        .time_evt  (time_evt)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        digit_cnt_d = digit_cnt_q;
        shift_d     = 1'b0;
        load_a_d    = 1'b0;
        load_c_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d     = '0;
                digit_cnt_d = '0;
                if (digit_evt) begin
                    shift_d     = 1'b1;
                    digit_cnt_d = 3'd1;
                    state_d     = ST_ENTRY;
                end else if (alarm_evt) begin
                    state_d = ST_SHOW_ALARM;
                end
            end

            ST_ENTRY: begin
                if (digit_evt) begin
                    shift_d = 1'b1;
                    timer_d = '0;
                    if (digit_cnt_q != MAX_DIGITS) begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end else if (alarm_evt || time_evt) begin
                    // Short entries ignore commit keys entirely, including a
                    // coincident tick, so the session is left exactly as it was.
                    if (digit_cnt_q == MAX_DIGITS) begin
                        load_a_d    = alarm_evt;
                        load_c_d    = time_evt;
                        state_d     = ST_IDLE;
                        timer_d     = '0;
                        digit_cnt_d = '0;
                    end
                end else if (one_second) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d     = ST_IDLE;
                        timer_d     = '0;
                        digit_cnt_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            ST_SHOW_ALARM: begin
                timer_d     = '0;
                digit_cnt_d = '0;
                if (key != KEY_ALARM) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                timer_d     = '0;
                digit_cnt_d = '0;
            end
        endcase

        show_new_time_d = (state_d == ST_ENTRY);
        show_a_d        = (state_d == ST_SHOW_ALARM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            digit_cnt_q     <= '0;
            shift_q         <= 1'b0;
            load_a_q        <= 1'b0;
            load_c_q        <= 1'b0;
            show_new_time_q <= 1'b0;
            show_a_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            digit_cnt_q     <= digit_cnt_d;
            shift_q         <= shift_d;
            load_a_q        <= load_a_d;
            load_c_q        <= load_c_d;
            show_new_time_q <= show_new_time_d;
            show_a_q        <= show_a_d;
        end
    end

    assign shift         = shift_q;
    assign load_new_a    = load_a_q;
    assign load_new_c    = load_c_q;
    assign show_new_time = show_new_time_q;
    assign show_a        = show_a_q;
    assign digit_cnt     = digit_cnt_q;

endmodule

// File: tb/tb_aclk_entry_ctrl.sv
// Directed self-checking bench for aclk_entry_ctrl with hand-computed
// expectations for entry, commit, timeout, edge detection and reset.
module tb_aclk_entry_ctrl;
    import aclk_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key = KEY_NONE;
    logic       shift, load_new_a, load_new_c, show_new_time, show_a;
    logic [2:0] digit_cnt;

    int checks = 0;
    int failures = 0;
    int n_shift = 0;
    int n_load_a = 0;
    int n_load_c = 0;
    int n_viol = 0;

    aclk_entry_ctrl #(.TIMEOUT_SEC(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .shift         (shift),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .show_new_time (show_new_time),
        .show_a        (show_a),
        .digit_cnt     (digit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (shift === 1'b1) n_shift++;
        if (load_new_a === 1'b1) n_load_a++;
        if (load_new_c === 1'b1) n_load_c++;
        if ((load_new_a === 1'b1 && load_new_c === 1'b1) ||
            (shift === 1'b1 && (load_new_a === 1'b1 || load_new_c === 1'b1))) n_viol++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        key = k;
        cyc(hold);
        key = KEY_NONE;
        cyc(2);
    endtask

    task automatic pulse_sec();
        one_second = 1'b1;
        cyc(1);
        one_second = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        key = KEY_NONE;
        one_second = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b expected=00000000",
                     {shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt});
        end
        cyc(2);
        reset = 1'b0;
        cyc(2);
        checks++;
        if (show_new_time !== 1'b0 || digit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_release actual=%b/%0d expected=0/0", show_new_time, digit_cnt);
        end
    endtask

    task automatic test_alarm_commit();
        logic [3:0] digits [4] = '{4'd2, 4'd3, 4'd5, 4'd9};
        int s0 = n_shift;
        int a0 = n_load_a;
        int c0 = n_load_c;
        for (int i = 0; i < 4; i++) begin
            press(digits[i], 3);
            checks++;
            if (digit_cnt !== 3'(i + 1)) begin
                failures++;
                $display("FAIL alarm_digit_cnt[%0d] actual=%0d expected=%0d", i, digit_cnt, i + 1);
            end
        end
        checks++;
        if (show_new_time !== 1'b1 || n_shift - s0 != 4) begin
            failures++;
            $display("FAIL alarm_entry actual=show%b shifts%0d expected=show1 shifts4",
                     show_new_time, n_shift - s0);
        end
        press(KEY_ALARM, 3);
        checks++;
        if (n_load_a - a0 != 1 || n_load_c - c0 != 0) begin
            failures++;
            $display("FAIL alarm_load actual=a%0d c%0d expected=a1 c0", n_load_a - a0, n_load_c - c0);
        end
        checks++;
        if (show_new_time !== 1'b0 || digit_cnt !== 3'd0 || show_a !== 1'b0) begin
            failures++;
            $display("FAIL alarm_idle actual=%b/%0d/%b expected=0/0/0", show_new_time, digit_cnt, show_a);
        end
    endtask

    task automatic test_short_commit();
        int a0 = n_load_a;
        int c0 = n_load_c;
        press(4'd1, 3);
        press(4'd2, 3);
        press(KEY_TIME, 3);
        press(KEY_ALARM, 3);
        checks++;
        if (n_load_c - c0 != 0 || n_load_a - a0 != 0) begin
            failures++;
            $display("FAIL short_no_load actual=a%0d c%0d expected=a0 c0", n_load_a - a0, n_load_c - c0);
        end
        checks++;
        if (show_new_time !== 1'b1 || digit_cnt !== 3'd2) begin
            failures++;
            $display("FAIL short_state actual=%b/%0d expected=1/2", show_new_time, digit_cnt);
        end
        press(4'd3, 3);
        press(4'd4, 3);
        press(4'd8, 3);
        checks++;
        if (digit_cnt !== 3'd4) begin
            failures++;
            $display("FAIL cnt_saturate actual=%0d expected=4", digit_cnt);
        end
        press(KEY_TIME, 3);
        checks++;
        if (n_load_c - c0 != 1 || n_load_a - a0 != 0 || show_new_time !== 1'b0) begin
            failures++;
            $display("FAIL time_commit actual=c%0d a%0d show%b expected=c1 a0 show0",
                     n_load_c - c0, n_load_a - a0, show_new_time);
        end
    endtask

    task automatic test_timeout();
        int a0 = n_load_a;
        int c0 = n_load_c;
        press(4'd7, 3);
        repeat (9) pulse_sec();
        checks++;
        if (show_new_time !== 1'b1 || digit_cnt !== 3'd1) begin
            failures++;
            $display("FAIL timeout_before actual=%b/%0d expected=1/1", show_new_time, digit_cnt);
        end
        pulse_sec();
        checks++;
        if (show_new_time !== 1'b0 || digit_cnt !== 3'd0 || n_load_a != a0 || n_load_c != c0) begin
            failures++;
            $display("FAIL timeout_idle actual=%b/%0d loads%0d expected=0/0 loads0",
                     show_new_time, digit_cnt, (n_load_a - a0) + (n_load_c - c0));
        end
    endtask

    task automatic test_held_key();
        int s0 = n_shift;
        key = 4'd4;
        cyc(20);
        key = 4'd6;
        cyc(5);
        key = KEY_NONE;
        cyc(2);
        checks++;
        if (n_shift - s0 != 1 || digit_cnt !== 3'd1) begin
            failures++;
            $display("FAIL held_key actual=shifts%0d cnt%0d expected=shifts1 cnt1", n_shift - s0, digit_cnt);
        end
        do_reset();
        s0 = n_shift;
        press(4'hC, 3);
        key = 4'hD;
        cyc(3);
        key = 4'd5;
        cyc(3);
        key = KEY_NONE;
        cyc(2);
        checks++;
        if (n_shift - s0 != 0 || show_new_time !== 1'b0) begin
            failures++;
            $display("FAIL reserved_key actual=shifts%0d show%b expected=shifts0 show0",
                     n_shift - s0, show_new_time);
        end
    endtask

    task automatic test_show_alarm();
        int c0 = n_load_c;
        key = KEY_ALARM;
        cyc(4);
        checks++;
        if (show_a !== 1'b1 || show_new_time !== 1'b0) begin
            failures++;
            $display("FAIL show_alarm_on actual=%b/%b expected=1/0", show_a, show_new_time);
        end
        key = KEY_NONE;
        cyc(1);
        checks++;
        if (show_a !== 1'b0) begin
            failures++;
            $display("FAIL show_alarm_off actual=%b expected=0", show_a);
        end
        press(KEY_TIME, 3);
        checks++;
        if (n_load_c != c0 || show_new_time !== 1'b0 || show_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_time_ignored actual=c%0d show%b expected=c0 show0", n_load_c - c0, show_new_time);
        end
    endtask

    task automatic test_coincident();
        press(4'd5, 3);
        repeat (8) pulse_sec();
        key = 4'd8;
        one_second = 1'b1;
        cyc(1);
        one_second = 1'b0;
        cyc(2);
        key = KEY_NONE;
        cyc(2);
        checks++;
        if (digit_cnt !== 3'd2) begin
            failures++;
            $display("FAIL coincident_cnt actual=%0d expected=2", digit_cnt);
        end
        repeat (9) pulse_sec();
        checks++;
        if (show_new_time !== 1'b1) begin
            failures++;
            $display("FAIL coincident_timer_cleared actual=%b expected=1", show_new_time);
        end
        pulse_sec();
        checks++;
        if (show_new_time !== 1'b0) begin
            failures++;
            $display("FAIL coincident_timeout actual=%b expected=0", show_new_time);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        press(4'd1, 3);
        press(4'd2, 3);
        press(4'd3, 3);
        checks++;
        if (digit_cnt !== 3'd3) begin
            failures++;
            $display("FAIL mid_cnt actual=%0d expected=3", digit_cnt);
        end
        key = 4'd4;
        cyc(1);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt} !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_async actual=%b expected=00000000",
                     {shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt});
        end
        cyc(2);
        reset = 1'b0;
        s0 = n_shift;
        cyc(4);
        checks++;
        if (n_shift != s0 || digit_cnt !== 3'd0 || show_new_time !== 1'b0) begin
            failures++;
            $display("FAIL held_through_reset actual=shifts%0d cnt%0d expected=shifts0 cnt0",
                     n_shift - s0, digit_cnt);
        end
        key = KEY_NONE;
        cyc(2);
        press(4'd9, 3);
        checks++;
        if (n_shift - s0 != 1 || digit_cnt !== 3'd1) begin
            failures++;
            $display("FAIL rearm_after_nokey actual=shifts%0d cnt%0d expected=shifts1 cnt1",
                     n_shift - s0, digit_cnt);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_viol != 0) begin
            failures++;
            $display("FAIL pulse_exclusive actual=%0d expected=0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_alarm_commit();
        test_short_commit();
        test_timeout();
        test_held_key();
        do_reset();
        test_show_alarm();
        test_coincident();
        test_reset_mid();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
